imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Writer side of the instruction memory. Receives a boot image as a byte stream and assembles little-endian 32-bit words. Drives a write port (WE/A/WD) into the instruction store; the fetch path later reads that store with a synchronous read of word A>>2. Holds the core off (BUSY) until the image has been written.

Parameters:
DEPTH, 256, instruction memory size in 32-bit words; the maximum accepted word count.
CNT_W, 16, width of the word-count header field and of the internal word counter.

Ports:
CLK  input  1  clock, rising edge.
RST_N  input  1  asynchronous active-low reset.
START  input  1  single-cycle pulse; begins a load when not busy.
BYTE_VALID  input  1  BYTE_DATA is valid.
BYTE_DATA  input  8  stream byte.
BYTE_READY  output  1  loader accepts a byte this cycle.
WE  output  1  instruction memory write enable, one-cycle pulse per word.
A  output  32  byte address of the write, word-aligned (word_idx<<2).
WD  output  32  write data.
BUSY  output  1  load in progress.
DONE  output  1  image loaded successfully; sticky.
ERR  output  1  image rejected; sticky.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE. BYTE_READY, WE, BUSY, DONE and ERR are 0. A=0, WD=0, word_idx=0, byte_idx=0. Reset during a load abandons it; words already written stay in memory.
- A byte transfers on a CLK edge when BYTE_VALID && BYTE_READY. BYTE_READY is a registered function of state: 1 in LEN0, LEN1, DATA (and CSUM when the option is enabled); 0 elsewhere.
- Stream format: N[7:0], N[15:8], then 4*N data bytes, least significant byte of each word first.
- IDLE/DONE/ERR: on START go to LEN0. On that edge clear DONE, ERR, word_idx and byte_idx. BUSY=1 in every state except IDLE, DONE and ERR.
- LEN0: accept byte into N[7:0], then go to LEN1.
- LEN1: accept byte into N[15:8]. If N==0 or N>DEPTH, go to ERR. Otherwise go to DATA.
- DATA: accept byte into WD[8*byte_idx +: 8], then byte_idx++. On the 4th byte (byte_idx==3), go to WRITE with byte_idx wrapping to 0.
- WRITE: lasts exactly one cycle; no bytes are accepted.
  - WE=1, A=word_idx<<2, WD holds the assembled word. The memory captures on the edge ending WRITE.
  - If word_idx==N-1, go to DONE (or CSUM when the option is enabled). Otherwise word_idx++ and go to DATA.
- DONE: DONE=1 and BUSY=0. ERR state: ERR=1 and BUSY=0. Both hold until the next START or reset.
- START while BUSY is ignored.
- BYTE_VALID is ignored while BYTE_READY=0; the byte is not consumed.
- Throughput: a word costs at least 5 cycles (4 byte cycles + 1 WRITE). Gaps in BYTE_VALID stall without losing state.
- A is word-aligned; bits [1:0] are always 0. The maximum address is (DEPTH-1)<<2, so there is no wrap-around.
- WE is never asserted outside WRITE, and never asserted twice for one word.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Enabled: after the last WRITE go to CSUM and accept one trailing byte. It must equal the XOR of all 4*N data bytes (the running XOR is cleared on START). If equal, go to DONE; if not, go to ERR. Data is already written either way.
- Disabled: no CSUM state, no trailing byte; the last WRITE goes directly to DONE.

Test Plan:
- Reset with RST_N=0 mid-DATA (word 2 of 5) -> WE, BUSY, DONE, ERR and BYTE_READY all drop to 0 immediately; a later START plus a full stream loads normally.
- START, then bytes 02 00 93 01 30 04 | 13 01 20 00 with BYTE_VALID held high -> two WE pulses: A=0x0 WD=0x04300193, then A=0x4 WD=0x00200113. DONE=1 and BUSY=0 afterwards.
- Header 00 00 -> ERR=1 with no WE pulse. Header 01 01 (N=257 > DEPTH=256) -> ERR=1. A following START with a valid stream clears ERR.
- N=256 with BYTE_VALID toggling randomly -> 256 WE pulses, last at A=0x3FC. Every word is correct and BYTE_READY=0 in every WRITE cycle.
- START pulsed during DATA -> ignored: word_idx and WD are unaffected and the load completes normally.
- With IMEM_LOADER_CHECKSUM_EN, N=1, data 13 00 00 00: trailing byte 13 -> DONE=1; trailing byte 00 -> ERR=1, still with exactly one WE at A=0x0 WD=0x00000013.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-image loader: turns a byte stream (16-bit LE word count, then LE words) into instruction-memory writes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        BYTE_VALID,
  input  logic [7:0]  BYTE_DATA,
  output logic        BYTE_READY,
  output logic        WE,
  output logic [31:0] A,
  output logic [31:0] WD,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   n_q;
  logic [CNT_W-1:0]   word_idx_q;
  logic [1:0]         byte_idx_q;
  logic [31:0]        wd_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q;
`endif

  logic               accept;
  logic               start_go;
  logic [CNT_W-1:0]   hdr_n;
  logic               len_bad;
  logic               last_word;

  assign accept    = BYTE_VALID && BYTE_READY;
  assign start_go  = START && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign hdr_n     = CNT_W'({BYTE_DATA, n_q[7:0]});
  assign len_bad   = (hdr_n == '0) || (32'(hdr_n) > 32'(DEPTH));
  assign last_word = (word_idx_q == n_q - CNT_W'(1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (START) state_d = S_LEN0;
      end
      S_LEN0: begin
        if (accept) state_d = S_LEN1;
      end
      S_LEN1: begin
        if (accept) state_d = len_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        if (accept && byte_idx_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_d = last_word ? S_CSUM : S_DATA;
`else
        state_d = last_word ? S_DONE : S_DATA;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) state_d = (BYTE_DATA == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BYTE_READY <= 1'b0;
      WE         <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      BYTE_READY <= (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                    || (state_d == S_CSUM)
`endif
                    ;
      WE         <= (state_d == S_WRITE);
      BUSY       <= !(state_d == S_IDLE || state_d == S_DONE || state_d == S_ERR);
      DONE       <= (state_d == S_DONE);
      ERR        <= (state_d == S_ERR);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      n_q        <= '0;
      word_idx_q <= '0;
      byte_idx_q <= 2'd0;
      wd_q       <= 32'd0;
    end else begin
      if (start_go) begin
        word_idx_q <= '0;
        byte_idx_q <= 2'd0;
      end
      if (accept && state_q == S_LEN0) n_q[7:0] <= BYTE_DATA;
      if (accept && state_q == S_LEN1) n_q <= hdr_n;
      if (accept && state_q == S_DATA) begin
        wd_q[{byte_idx_q, 3'b000} +: 8] <= BYTE_DATA;
        byte_idx_q <= byte_idx_q + 2'd1;
      end
      if (state_q == S_WRITE && !last_word) word_idx_q <= word_idx_q + CNT_W'(1);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                            csum_q <= 8'd0;
    else if (start_go)                     csum_q <= 8'd0;
    else if (accept && state_q == S_DATA)  csum_q <= csum_q ^ BYTE_DATA;
  end
`endif

  assign A  = {{(30-CNT_W){1'b0}}, word_idx_q, 2'b00};
  assign WD = wd_q;

  a_we_in_write: assert property (@(posedge CLK) disable iff (!RST_N) WE |-> (state_q == S_WRITE));
  a_we_single:   assert property (@(posedge CLK) disable iff (!RST_N) WE |=> !WE);
  a_no_rdy_we:   assert property (@(posedge CLK) disable iff (!RST_N) WE |-> !BYTE_READY);
  a_flags_excl:  assert property (@(posedge CLK) disable iff (!RST_N) !(DONE && ERR) && !(BUSY && (DONE || ERR)));

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: logs every WE pulse and checks it against hand-computed words.
module tb_imem_loader;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic        BYTE_VALID = 1'b0;
  logic [7:0]  BYTE_DATA = 8'd0;
  logic        BYTE_READY, WE, BUSY, DONE, ERR;
  logic [31:0] A, WD;

  imem_loader #(.DEPTH(256), .CNT_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START),
    .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA), .BYTE_READY(BYTE_READY),
    .WE(WE), .A(A), .WD(WD), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] mem [256];
  logic [31:0] img [256];
  logic [31:0] log_a [$];
  logic [31:0] log_d [$];
  int          rdy_viol = 0;
  logic [7:0]  txor;

  always @(negedge CLK) begin
    if (WE) begin
      log_a.push_back(A);
      log_d.push_back(WD);
      mem[A[9:2]] = WD;
      if (BYTE_READY) rdy_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic prep(input int salt);
    log_a.delete();
    log_d.delete();
    rdy_viol = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'hDEADBEEF;
      img[i] = {8'(i) ^ 8'h5A, 8'(i + salt), ~8'(i), 8'(i * 3)};
    end
  endtask

  task automatic start_pulse();
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge CLK);
    BYTE_VALID = 1'b1;
    BYTE_DATA  = b;
    while (!BYTE_READY && t < 64) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 64) check("byte_timeout", 32'd0, 32'd1);
    else @(negedge CLK);
    BYTE_VALID = 1'b0;
  endtask

  task automatic send_header(input int n);
    txor = 8'd0;
    send_byte(8'(n), 1'b0);
    send_byte(8'(n >> 8), 1'b0);
  endtask

  task automatic send_data_byte(input logic [7:0] b, input bit gaps);
    txor = txor ^ b;
    send_byte(b, gaps);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_data_byte(w[8*k +: 8], gaps);
  endtask

  task automatic wait_end();
    int t = 0;
    while (!(DONE || ERR) && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 200) check("end_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_image();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(txor, 1'b0);
`endif
    wait_end();
  endtask

  function automatic int mem_errs(input int n);
    int e = 0;
    for (int i = 0; i < n; i++) if (mem[i] !== img[i]) e++;
    return e;
  endfunction

  initial begin
    prep(0);
    #3;
    check("rst_flags", {27'd0, BYTE_READY, WE, BUSY, DONE, ERR}, 32'd0);
    check("rst_a", A, 32'd0);
    check("rst_wd", WD, 32'd0);
    @(negedge CLK); RST_N = 1'b1;

    // Two-word image, valid held high.
    prep(1);
    img[0] = 32'h04300193;
    img[1] = 32'h00200113;
    start_pulse();
    check("basic_busy", {31'd0, BUSY}, 32'd1);
    send_header(2);
    send_word(img[0], 1'b0);
    send_word(img[1], 1'b0);
    finish_image();
    check("basic_we_cnt", log_a.size(), 32'd2);
    if (log_a.size() == 2) begin
      check("basic_a0", log_a[0], 32'h0);
      check("basic_d0", log_d[0], 32'h04300193);
      check("basic_a1", log_a[1], 32'h4);
      check("basic_d1", log_d[1], 32'h00200113);
    end
    check("basic_done_busy_err", {29'd0, DONE, BUSY, ERR}, 32'b100);

    // Length errors.
    prep(2);
    start_pulse();
    check("start_clears_done", {31'd0, DONE}, 32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_end();
    check("n0_err_done_busy", {29'd0, ERR, DONE, BUSY}, 32'b100);
    check("n0_no_we", log_a.size(), 32'd0);
    start_pulse();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    wait_end();
    check("n257_err", {31'd0, ERR}, 32'd1);
    check("n257_no_we", log_a.size(), 32'd0);
    start_pulse();
    check("start_clears_err", {30'd0, ERR, BUSY}, 32'b01);
    send_header(1);
    send_word(img[0], 1'b0);
    finish_image();
    check("recover_done_err", {30'd0, DONE, ERR}, 32'b10);
    check("recover_word", mem[0], img[0]);

    // START while busy in DATA is ignored.
    prep(3);
    start_pulse();
    send_header(3);
    send_data_byte(img[0][7:0], 1'b0);
    send_data_byte(img[0][15:8], 1'b0);
    start_pulse();
    check("busy_start_busy", {31'd0, BUSY}, 32'd1);
    send_data_byte(img[0][23:16], 1'b0);
    send_data_byte(img[0][31:24], 1'b0);
    send_word(img[1], 1'b0);
    send_word(img[2], 1'b0);
    finish_image();
    check("busy_start_cnt", log_a.size(), 32'd3);
    check("busy_start_words", mem_errs(3), 32'd0);
    check("busy_start_done", {31'd0, DONE}, 32'd1);

    // Reset in the middle of word 2 of 5.
    prep(4);
    start_pulse();
    send_header(5);
    send_word(img[0], 1'b0);
    send_word(img[1], 1'b0);
    send_data_byte(img[2][7:0], 1'b0);
    send_data_byte(img[2][15:8], 1'b0);
    RST_N = 1'b0;
    #1;
    check("midrst_flags", {27'd0, BYTE_READY, WE, BUSY, DONE, ERR}, 32'd0);
    check("midrst_a", A, 32'd0);
    check("midrst_words_kept", log_a.size(), 32'd2);
    @(negedge CLK); RST_N = 1'b1;
    log_a.delete();
    log_d.delete();
    start_pulse();
    send_header(5);
    for (int i = 0; i < 5; i++) send_word(img[i], 1'b0);
    finish_image();
    check("midrst_reload_cnt", log_a.size(), 32'd5);
    check("midrst_reload_words", mem_errs(5), 32'd0);

    // Full-depth image with random valid gaps.
    prep(5);
    start_pulse();
    send_header(256);
    for (int i = 0; i < 256; i++) send_word(img[i], 1'b1);
    finish_image();
    check("full_cnt", log_a.size(), 32'd256);
    if (log_a.size() == 256) check("full_last_a", log_a[255], 32'h3FC);
    check("full_words", mem_errs(256), 32'd0);
    check("full_rdy_in_write", rdy_viol, 32'd0);
    check("full_done", {30'd0, DONE, ERR}, 32'b10);

`ifdef IMEM_LOADER_CHECKSUM_EN
    prep(6);
    start_pulse();
    send_header(1);
    send_word(32'h00000013, 1'b0);
    send_byte(8'h13, 1'b0);
    wait_end();
    check("csum_good", {30'd0, DONE, ERR}, 32'b10);
    log_a.delete();
    log_d.delete();
    start_pulse();
    send_header(1);
    send_word(32'h00000013, 1'b0);
    send_byte(8'h00, 1'b0);
    wait_end();
    check("csum_bad", {30'd0, DONE, ERR}, 32'b01);
    check("csum_bad_cnt", log_a.size(), 32'd1);
    if (log_a.size() == 1) begin
      check("csum_bad_a", log_a[0], 32'h0);
      check("csum_bad_d", log_d[0], 32'h00000013);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
